linked_fifo_engine: RTL

LINKED_FIFO_ENGINE -- requirements
Module: linked_fifo_engine

---
 rtl/linked_fifo_pkg.sv | 19 +
 rtl/fifo_cell_alloc.sv | 59 +++++
 rtl/tc_sram.sv | 30 +++
 rtl/linked_fifo_engine.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/linked_fifo_pkg.sv
// Shared types for the linked-list FIFO engine.
package linked_fifo_pkg;

  // Widest cell pointer stored in a link. Each instance narrows it to its own index width.
  localparam int unsigned PTR_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    ptr_t next;
    logic is_last;
  } cell_t;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_cell_alloc.sv
// Free-cell search: lowest free static cell of the requested FIFO's partition,
// lowest free dynamic cell, per-partition full flags and the free dynamic count.
module fifo_cell_alloc
  import linked_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFO  = 16,
  parameter int unsigned NUM_CELLS = 64,
  parameter int unsigned NS        = 4,
  parameter int unsigned TOT_CELLS = NUM_CELLS + NS * NUM_FIFO,
  parameter int unsigned IDX_W     = idx_width(TOT_CELLS),
  parameter int unsigned FIFO_W    = $clog2(NUM_FIFO),
  parameter int unsigned CNT_W     = $clog2(NUM_CELLS + 1)
) (
  input  logic [TOT_CELLS-1:0] busy_i,
  input  logic [FIFO_W-1:0]    fifo_i,
  output logic [IDX_W-1:0]     alloc_idx_o,
  output logic [NUM_FIFO-1:0]  stat_full_o,
  output logic                 dyn_avail_o,
  output logic [CNT_W-1:0]     dyn_free_o
);

  logic [NUM_FIFO-1:0][NS-1:0] part_busy;
  logic [NUM_CELLS-1:0]        dyn_free_vec;
  logic [NS-1:0]               stat_free_vec;
  logic [IDX_W-1:0]            dyn_idx;
  logic [IDX_W-1:0]            stat_off;
  logic [IDX_W-1:0]            stat_idx;

  for (genvar f = 0; f < NUM_FIFO; f++) begin : g_part
    assign part_busy[f]   = busy_i[NUM_CELLS + f*NS +: NS];
    assign stat_full_o[f] = &part_busy[f];
  end

  // Dynamic pool: leading-zero count of the bit-reversed free map gives the lowest free index.
  always_comb begin
    dyn_free_vec = ~busy_i[NUM_CELLS-1:0];
    dyn_idx      = '0;
    dyn_free_o   = '0;
    for (int unsigned i = NUM_CELLS; i > 0; i--) begin
      if (dyn_free_vec[i-1]) dyn_idx = IDX_W'(i - 1);
    end
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      dyn_free_o = dyn_free_o + CNT_W'(dyn_free_vec[i]);
    end
    dyn_avail_o = |dyn_free_vec;
  end

  // Static partition of the requested FIFO: same lowest-free search, then pick pool.
  always_comb begin
    stat_free_vec = ~part_busy[fifo_i];
    stat_off      = '0;
    for (int unsigned j = NS; j > 0; j--) begin
      if (stat_free_vec[j-1]) stat_off = IDX_W'(j - 1);
    end
    stat_idx    = IDX_W'(NUM_CELLS + NS * 32'(fifo_i)) + stat_off;
    alloc_idx_o = stat_full_o[fifo_i] ? dyn_idx : stat_idx;
  end

endmodule

// File: rtl/tc_sram.sv
// Two-port element store: one write port, one read port, registered read data.
module tc_sram #(
  parameter int unsigned NUM_WORDS = 64,
  parameter type         data_t    = logic [31:0],
  parameter int unsigned AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  data_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output data_t         rdata_o
);

  data_t mem [NUM_WORDS];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: one cycle latency, output holds between reads and clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/linked_fifo_engine.sv
// Many logical FIFOs as singly linked lists over static per-FIFO cells plus a shared dynamic pool.
module linked_fifo_engine
  import linked_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFO                  = 16,
  parameter int unsigned NUM_CELLS                 = 64,
  parameter int unsigned NUM_STATIC_CELLS_PER_FIFO = 4,
  parameter type         elem_t                    = logic [31:0],
  parameter int unsigned TOT_CELLS = NUM_CELLS + NUM_STATIC_CELLS_PER_FIFO * NUM_FIFO,
  parameter int unsigned OCC_W     = $clog2(NUM_STATIC_CELLS_PER_FIFO + NUM_CELLS + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [$clog2(NUM_FIFO)-1:0]        push_fifo_i,
  input  elem_t                              push_data_i,
  input  logic                               pop_valid_i,
  output logic                               pop_ready_o,
  input  logic [$clog2(NUM_FIFO)-1:0]        pop_fifo_i,
  output elem_t                              pop_data_o,
  output logic                               pop_data_valid_o,
  output logic [NUM_FIFO-1:0]                fifo_empty_o,
  output logic [NUM_FIFO-1:0]                fifo_full_o,
  output logic [NUM_FIFO-1:0][OCC_W-1:0]     fifo_occup_o,
  output logic [$clog2(NUM_CELLS+1)-1:0]     free_dyn_cells_o
);

  localparam int unsigned IDX_W  = idx_width(TOT_CELLS);
  localparam int unsigned FIFO_W = $clog2(NUM_FIFO);
  localparam int unsigned CNT_W  = $clog2(NUM_CELLS + 1);

  logic [TOT_CELLS-1:0] busy_q;
  cell_t                cells_q [TOT_CELLS];
  logic [IDX_W-1:0]     head_q  [NUM_FIFO];
  logic [IDX_W-1:0]     tail_q  [NUM_FIFO];
  logic [OCC_W-1:0]     occ_q   [NUM_FIFO];
  logic                 pop_vld_q;

  logic [NUM_FIFO-1:0]  stat_full;
  logic                 dyn_avail;
  logic [IDX_W-1:0]     new_idx;
  logic [IDX_W-1:0]     pop_idx;
  logic [IDX_W-1:0]     pop_next;
  logic [IDX_W-1:0]     push_tail;
  cell_t                pop_cell;
  logic                 push_acc;
  logic                 pop_acc;
  logic                 push_to_empty;
  logic [NUM_FIFO-1:0]  push_sel;
  logic [NUM_FIFO-1:0]  pop_sel;

  fifo_cell_alloc #(
    .NUM_FIFO  (NUM_FIFO),
    .NUM_CELLS (NUM_CELLS),
    .NS        (NUM_STATIC_CELLS_PER_FIFO),
    .TOT_CELLS (TOT_CELLS),
    .IDX_W     (IDX_W),
    .FIFO_W    (FIFO_W),
    .CNT_W     (CNT_W)
  ) u_alloc (
    .busy_i      (busy_q),
    .fifo_i      (push_fifo_i),
    .alloc_idx_o (new_idx),
    .stat_full_o (stat_full),
    .dyn_avail_o (dyn_avail),
    .dyn_free_o  (free_dyn_cells_o)
  );

  tc_sram #(
    .NUM_WORDS (TOT_CELLS),
    .data_t    (elem_t),
    .AW        (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push_acc),
    .waddr_i (new_idx),
    .wdata_i (push_data_i),
    .re_i    (pop_acc),
    .raddr_i (pop_idx),
    .rdata_o (pop_data_o)
  );

  // Status from registered state only.
  always_comb begin
    for (int unsigned f = 0; f < NUM_FIFO; f++) begin
      fifo_empty_o[f] = (occ_q[f] == '0);
      fifo_occup_o[f] = occ_q[f];
    end
    fifo_full_o      = stat_full & {NUM_FIFO{~dyn_avail}};
    pop_data_valid_o = pop_vld_q;
  end

  // Handshake decode and list pointers for this cycle's push and pop.
  always_comb begin
    push_ready_o = ~fifo_full_o[push_fifo_i];
    pop_ready_o  = ~fifo_empty_o[pop_fifo_i];
    push_acc     = push_valid_i & push_ready_o;
    pop_acc      = pop_valid_i & pop_ready_o;
    pop_idx      = head_q[pop_fifo_i];
    pop_cell     = cells_q[pop_idx];
    pop_next     = IDX_W'(pop_cell.next);
    push_tail    = tail_q[push_fifo_i];
    // A pop taking the last element of the same FIFO leaves the new cell as sole member.
    push_to_empty = fifo_empty_o[push_fifo_i]
                  | (pop_acc & (pop_fifo_i == push_fifo_i) & pop_cell.is_last);
    push_sel = '0;
    pop_sel  = '0;
    if (push_acc) push_sel[push_fifo_i] = 1'b1;
    if (pop_acc)  pop_sel[pop_fifo_i]   = 1'b1;
  end

  // Link storage: new cell terminates its list; the old tail links to it unless it is being freed.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      cells_q[new_idx] <= '{next: '0, is_last: 1'b1};
      if (!push_to_empty) cells_q[push_tail] <= '{next: ptr_t'(new_idx), is_last: 1'b0};
    end
  end

  // Allocation map, head/tail pointers, occupancy and pop-data strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      pop_vld_q <= 1'b0;
      for (int unsigned f = 0; f < NUM_FIFO; f++) begin
        head_q[f] <= '0;
        tail_q[f] <= '0;
        occ_q[f]  <= '0;
      end
    end else begin
      pop_vld_q <= pop_acc;
      if (pop_acc) begin
        busy_q[pop_idx]     <= 1'b0;
        head_q[pop_fifo_i]  <= pop_next;
      end
      // Ordered after the pop so a same-FIFO refill overrides the advanced head.
      if (push_acc) begin
        busy_q[new_idx]       <= 1'b1;
        tail_q[push_fifo_i]   <= new_idx;
        if (push_to_empty) head_q[push_fifo_i] <= new_idx;
      end
      for (int unsigned f = 0; f < NUM_FIFO; f++) begin
        if (push_sel[f] && !pop_sel[f])      occ_q[f] <= occ_q[f] + OCC_W'(1);
        else if (!push_sel[f] && pop_sel[f]) occ_q[f] <= occ_q[f] - OCC_W'(1);
      end
    end
  end

endmodule
